serial_frame_rx: RTL and testbench

Framed serial receiver that sits directly downstream of the parallel-to-serial stage's line output. It oversamples an asynchronous start/stop-framed line and recovers each DATA_W-bit word, transmitted LSB first to match the serializer's shift order. Each word is presented on a one-entry parallel output buffer with a valid/ready handshake. Framing and parity errors are flagged per frame, and the block sits in front of any word-wide consumer.

---
 rtl/serial_pkg.sv | 23 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/serial_frame_rx.sv | 168 ++++++++++++++++
 tb/tb_serial_frame_rx.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the serial line path: receiver state encoding,
// idle line level and a width helper used on both serializer and receiver sides.
package serial_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_e;

  localparam logic LINE_IDLE = 1'b1;

  // Bits needed to hold values 0..n-1; never less than one bit.
  function automatic int clog2w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input; the reset value
// is a parameter so a line can come out of reset at its idle level.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      q_o    <= RST_VAL;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/serial_frame_rx.sv
// Oversampling start/stop framed serial receiver, LSB first, optional parity,
// with a one-entry valid/ready output buffer and per-frame error pulses.
module serial_frame_rx
  import serial_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              frame_err,
  output logic              parity_err,
  output logic              overrun,
  output logic              busy
);

  localparam int CW = clog2w(CLKS_PER_BIT);
  localparam int BW = clog2w(DATA_W + 1);
  localparam logic [CW-1:0] C_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] C_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_W - 1);
  localparam logic          ODD    = (PARITY_ODD != 0);
  localparam logic          HAS_PAR = (PARITY_EN != 0);

  logic              din_s;
  logic              din_dly_q;
  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              par_bad_q, par_bad_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              vld_q, vld_d;
  logic              ferr_q, ferr_d;
  logic              perr_q, perr_d;
  logic              ovr_q, ovr_d;

  sync_2ff #(
    .RST_VAL(LINE_IDLE)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d_i (din),
    .q_o (din_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      din_dly_q <= LINE_IDLE;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      par_bad_q <= 1'b0;
      dout_q    <= '0;
      vld_q     <= 1'b0;
      ferr_q    <= 1'b0;
      perr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      din_dly_q <= din_s;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      par_bad_q <= par_bad_d;
      dout_q    <= dout_d;
      vld_q     <= vld_d;
      ferr_q    <= ferr_d;
      perr_q    <= perr_d;
      ovr_q     <= ovr_d;
    end
  end

  // The shift register carries only data; the control path decides what is kept.
  always_ff @(posedge clk) begin
    shreg_q <= shreg_d;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_d     = bit_q;
    shreg_d   = shreg_q;
    par_bad_d = par_bad_q;
    dout_d    = dout_q;
    vld_d     = vld_q;
    ferr_d    = 1'b0;
    perr_d    = 1'b0;
    ovr_d     = 1'b0;

    if (vld_q && dout_ready) vld_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (din_dly_q == LINE_IDLE && din_s != LINE_IDLE) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == C_HALF) begin
          cnt_d     = '0;
          bit_d     = '0;
          par_bad_d = 1'b0;
          state_d   = (din_s == LINE_IDLE) ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == C_LAST) begin
          cnt_d              = '0;
          shreg_d            = shreg_q >> 1;
          shreg_d[DATA_W-1]  = din_s;
          bit_d              = bit_q + BW'(1);
          if (bit_q == B_LAST) state_d = HAS_PAR ? PARITY : STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      PARITY: begin
        if (cnt_q == C_LAST) begin
          cnt_d     = '0;
          par_bad_d = din_s ^ (^shreg_q) ^ ODD;
          state_d   = STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == C_LAST) begin
          cnt_d   = '0;
          state_d = IDLE;
          // A broken stop bit outranks a parity error for the same frame.
          if (din_s != LINE_IDLE) begin
            ferr_d = 1'b1;
          end else if (par_bad_q) begin
            perr_d = 1'b1;
          end else if (!vld_q || dout_ready) begin
            dout_d = shreg_q;
            vld_d  = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign dout       = dout_q;
  assign dout_valid = vld_q;
  assign frame_err  = ferr_q;
  assign parity_err = perr_q;
  assign overrun    = ovr_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_serial_frame_rx.sv
// Directed bench for serial_frame_rx: one instance without parity, one with even parity.
module tb_serial_frame_rx;

  localparam int N = 16;

  logic       clk;
  logic       rst;
  logic       din0, din1;
  logic       rdy0, rdy1;
  logic [7:0] dout0, dout1;
  logic       vld0, vld1;
  logic       ferr0, ferr1;
  logic       perr0, perr1;
  logic       ovr0, ovr1;
  logic       busy0, busy1;

  int checks = 0;
  int errors = 0;
  int fe0 = 0, pe0 = 0, ov0 = 0;
  int fe1 = 0, pe1 = 0, ov1 = 0;

  serial_frame_rx #(
    .DATA_W(8), .CLKS_PER_BIT(N), .PARITY_EN(0), .PARITY_ODD(0)
  ) dut0 (
    .clk(clk), .rst(rst), .din(din0), .dout(dout0), .dout_valid(vld0),
    .dout_ready(rdy0), .frame_err(ferr0), .parity_err(perr0),
    .overrun(ovr0), .busy(busy0)
  );

  serial_frame_rx #(
    .DATA_W(8), .CLKS_PER_BIT(N), .PARITY_EN(1), .PARITY_ODD(0)
  ) dut1 (
    .clk(clk), .rst(rst), .din(din1), .dout(dout1), .dout_valid(vld1),
    .dout_ready(rdy1), .frame_err(ferr1), .parity_err(perr1),
    .overrun(ovr1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    fe0 <= fe0 + int'(ferr0);
    pe0 <= pe0 + int'(perr0);
    ov0 <= ov0 + int'(ovr0);
    fe1 <= fe1 + int'(ferr1);
    pe1 <= pe1 + int'(perr1);
    ov1 <= ov1 + int'(ovr1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Each line bit is held for N clocks, starting at the current falling edge.
  task automatic tx0(input logic [31:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      din0 = bits[i];
      repeat (N) @(negedge clk);
    end
  endtask

  task automatic tx1(input logic [31:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      din1 = bits[i];
      repeat (N) @(negedge clk);
    end
  endtask

  initial begin
    rst  = 1'b1;
    din0 = 1'b1;
    din1 = 1'b1;
    rdy0 = 1'b0;
    rdy1 = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_dout0", dout0, 0);
    chk("rst_vld0", vld0, 0);
    chk("rst_busy0", busy0, 0);
    chk("rst_flags0", {ferr0, perr0, ovr0}, 0);
    chk("rst_vld1", vld1, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 0xA5 with exact latency of dout_valid and busy
    rdy0 = 1'b1;
    tx0({23'b0, 8'hA5, 1'b0}, 9);
    din0 = 1'b1;
    repeat (10) @(negedge clk);
    chk("a5_vld_early", vld0, 0);
    chk("a5_busy_stop", busy0, 1);
    @(negedge clk);
    chk("a5_vld", vld0, 1);
    chk("a5_dout", dout0, 32'hA5);
    chk("a5_busy_end", busy0, 0);
    @(negedge clk);
    chk("a5_vld_1cyc", vld0, 0);
    repeat (8) @(negedge clk);
    chk("a5_flags", {fe0[3:0], pe0[3:0], ov0[3:0]}, 0);

    // back-to-back 0x3C, 0xC3 with consumer stalled
    rdy0 = 1'b0;
    tx0({21'b0, 1'b1, 8'h3C, 1'b0}, 10);
    tx0({21'b0, 1'b1, 8'hC3, 1'b0}, 10);
    repeat (4) @(negedge clk);
    chk("ovr_dout_held", dout0, 32'h3C);
    chk("ovr_vld", vld0, 1);
    chk("ovr_count", ov0, 1);
    chk("ovr_no_ferr", fe0, 0);
    rdy0 = 1'b1;
    @(negedge clk);
    chk("ovr_accept_clr", vld0, 0);
    rdy0 = 1'b0;
    repeat (4) @(negedge clk);

    // 3-cycle low glitch on idle line
    din0 = 1'b0;
    repeat (3) @(negedge clk);
    din0 = 1'b1;
    chk("glitch_busy", busy0, 1);
    repeat (9) @(negedge clk);
    chk("glitch_idle", busy0, 0);
    repeat (2 * N) @(negedge clk);
    chk("glitch_vld", vld0, 0);
    chk("glitch_flags", {fe0[3:0], pe0[3:0], ov0[3:0]}, 12'h001);

    // 0x5A with a stop bit held low for two bit periods
    tx0({23'b0, 8'h5A, 1'b0}, 9);
    din0 = 1'b0;
    repeat (2 * N) @(negedge clk);
    din0 = 1'b1;
    repeat (2 * N) @(negedge clk);
    chk("ferr_count", fe0, 1);
    chk("ferr_vld", vld0, 0);
    chk("ferr_no_perr", pe0, 0);
    tx0({21'b0, 1'b1, 8'h01, 1'b0}, 10);
    repeat (4) @(negedge clk);
    chk("after_ferr_vld", vld0, 1);
    chk("after_ferr_dout", dout0, 32'h01);

    // even parity: 0x07 needs parity bit 1
    tx1({20'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
    repeat (4) @(negedge clk);
    chk("par_ok_vld", vld1, 1);
    chk("par_ok_dout", dout1, 32'h07);
    chk("par_ok_perr", pe1, 0);
    rdy1 = 1'b1;
    @(negedge clk);
    chk("par_ok_accept", vld1, 0);
    rdy1 = 1'b0;
    tx1({20'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
    repeat (4) @(negedge clk);
    chk("par_bad_count", pe1, 1);
    chk("par_bad_vld", vld1, 0);
    chk("par_bad_dout", dout1, 32'h07);
    chk("par_bad_ferr", fe1, 0);

    // reset in the middle of DATA for 0xFF
    din0 = 1'b0;
    repeat (N) @(negedge clk);
    din0 = 1'b1;
    repeat (3 * N) @(negedge clk);
    chk("mid_busy", busy0, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_dout0", dout0, 0);
    chk("mid_rst_vld0", vld0, 0);
    chk("mid_rst_busy0", busy0, 0);
    chk("mid_rst_dout1", dout1, 0);
    repeat (8 * N) @(negedge clk);
    chk("mid_rest_vld", vld0, 0);
    chk("mid_rest_busy", busy0, 0);
    tx0({21'b0, 1'b1, 8'h81, 1'b0}, 10);
    repeat (4) @(negedge clk);
    chk("post_rst_vld", vld0, 1);
    chk("post_rst_dout", dout0, 32'h81);
    chk("post_rst_flags", {fe0[3:0], pe0[3:0], ov0[3:0]}, 12'h101);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
